// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several FIFO-backed byte sources.
// One pop per transmitted byte, bursts of up to MAX_BURST bytes per grant, watchdog on a stalled UART.
module uart_tx_arbiter #(
    parameter int N_REQ          = 2,
    parameter int DATA_BITS      = 8,
    parameter int RD_LATENCY     = 1,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                       sysclk,
    input  logic                       nrst_in,
    input  logic [N_REQ-1:0]           req_empty_in,
    input  logic [N_REQ*DATA_BITS-1:0] req_data_in,
    output logic [N_REQ-1:0]           req_read_out,
    output logic [DATA_BITS-1:0]       tx_data_out,
    output logic                       tx_start_out,
    input  logic                       tx_done_in,
    output logic [N_REQ-1:0]           grant_out,
    output logic                       busy_out,
    output logic                       timeout_err_out,
    input  logic                       err_clr_in
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_DATA,
        ST_LAUNCH,
        ST_WAIT_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [N_REQ-1:0]     req;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     next_ptr;
    logic                 pick_valid;
    logic [BURST_W-1:0]   burst_cnt;
    logic [LAT_W-1:0]     lat_cnt;
    logic [WD_W-1:0]      watchdog;
    logic                 lat_last;
    logic                 expired;
    logic                 keep_grant;
    logic                 release_grant;

    assign req           = ~req_empty_in;
    assign lat_last      = (lat_cnt == LAT_W'(RD_LATENCY - 1));
    assign next_ptr      = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign keep_grant    = (burst_cnt < BURST_W'(MAX_BURST)) && !req_empty_in[grant_idx];
    // A done pulse on the expiry cycle wins, so expiry is qualified by its absence.
    assign expired       = (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) && !tx_done_in;
    assign release_grant = (state == ST_WAIT_DONE) && ((tx_done_in && !keep_grant) || expired);

    // Walk offsets from the far end so the closest requester to rr_ptr is assigned last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (pick_valid) state_next = ST_READ;
            ST_READ:      state_next = ST_WAIT_DATA;
            ST_WAIT_DATA: if (lat_last) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done_in) begin
                    state_next = keep_grant ? ST_READ : ST_IDLE;
                end else if (expired) begin
                    state_next = ST_IDLE;
                end
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so they vanish the moment reset asserts.
    always_comb begin
        req_read_out = (state == ST_READ) ? grant_out : '0;
        tx_start_out = (state == ST_LAUNCH);
        busy_out     = (state != ST_IDLE);
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            rr_ptr          <= '0;
            grant_idx       <= '0;
            grant_out       <= '0;
            burst_cnt       <= '0;
            lat_cnt         <= '0;
            watchdog        <= '0;
            tx_data_out     <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        grant_out <= N_REQ'(1) << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                ST_READ: begin
                    lat_cnt <= '0;
                end
                ST_WAIT_DATA: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_last) begin
                        tx_data_out <= req_data_in[grant_idx*DATA_BITS +: DATA_BITS];
                    end
                end
                ST_LAUNCH: begin
                    burst_cnt <= burst_cnt + 1'b1;
                    watchdog  <= '0;
                end
                ST_WAIT_DONE: begin
                    watchdog <= watchdog + 1'b1;
                    if (release_grant) begin
                        rr_ptr    <= next_ptr;
                        grant_out <= '0;
                    end
                end
                default: ;
            endcase

            if ((state == ST_WAIT_DONE) && expired) begin
                timeout_err_out <= 1'b1;
            end else if (err_clr_in) begin
                timeout_err_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two FIFO models, a UART model with programmable done delay.
// Expected bytes are queued per FIFO at push time and compared at every tx_start_out.
module tb_uart_tx_arbiter;

    localparam int N_REQ          = 2;
    localparam int DATA_BITS      = 8;
    localparam int RD_LATENCY     = 1;
    localparam int MAX_BURST      = 4;
    localparam int TIMEOUT_CYCLES = 50;

    logic                       sysclk;
    logic                       nrst_in;
    logic [N_REQ-1:0]           req_empty_in;
    logic [N_REQ*DATA_BITS-1:0] req_data_in;
    logic [N_REQ-1:0]           req_read_out;
    logic [DATA_BITS-1:0]       tx_data_out;
    logic                       tx_start_out;
    logic                       tx_done_in;
    logic [N_REQ-1:0]           grant_out;
    logic                       busy_out;
    logic                       timeout_err_out;
    logic                       err_clr_in;

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .DATA_BITS(DATA_BITS),
        .RD_LATENCY(RD_LATENCY),
        .MAX_BURST(MAX_BURST),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .sysclk(sysclk),
        .nrst_in(nrst_in),
        .req_empty_in(req_empty_in),
        .req_data_in(req_data_in),
        .req_read_out(req_read_out),
        .tx_data_out(tx_data_out),
        .tx_start_out(tx_start_out),
        .tx_done_in(tx_done_in),
        .grant_out(grant_out),
        .busy_out(busy_out),
        .timeout_err_out(timeout_err_out),
        .err_clr_in(err_clr_in)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    logic [7:0]       fifo0[$];
    logic [7:0]       fifo1[$];
    logic [7:0]       exp0[$];
    logic [7:0]       exp1[$];
    int               start_grant[$];
    int               start_session[$];
    int               session = 0;
    int               pops_since_start = 0;
    int               total_reads = 0;
    int               read_cycle = -1;
    int               start_cycle = -1;
    int               uart_cnt = 0;
    int               uart_delay = 3;
    logic             pending_valid = 1'b0;
    logic [7:0]       pending_byte = '0;
    int               pending_idx = 0;
    logic [N_REQ-1:0] prev_grant = '0;
    int               err_count = 0;
    int               check_count = 0;
    logic             tmp_ok;
    logic [7:0]       tmp_b;
    int               base;
    logic             done_flag;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic int idx_of(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic update_flags();
        req_empty_in = {fifo1.size() == 0, fifo0.size() == 0};
    endtask

    task automatic fifo_take(input int idx, output logic ok, output logic [7:0] b);
        ok = 1'b0;
        b  = '0;
        if (idx == 0 && fifo0.size() > 0) begin ok = 1'b1; b = fifo0.pop_front(); end
        if (idx == 1 && fifo1.size() > 0) begin ok = 1'b1; b = fifo1.pop_front(); end
    endtask

    task automatic exp_take(input int idx, output logic ok, output logic [7:0] b);
        ok = 1'b0;
        b  = '0;
        if (idx == 0 && exp0.size() > 0) begin ok = 1'b1; b = exp0.pop_front(); end
        if (idx == 1 && exp1.size() > 0) begin ok = 1'b1; b = exp1.pop_front(); end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] b);
        if (idx == 0) begin fifo0.push_back(b); exp0.push_back(b); end
        else          begin fifo1.push_back(b); exp1.push_back(b); end
        update_flags();
    endtask

    // One cycle: sample DUT outputs at the falling edge, then advance the FIFO and UART models.
    task automatic tick();
        int g;
        int r;
        @(negedge sysclk);
        if (!nrst_in) begin
            pending_valid    = 1'b0;
            uart_cnt         = 0;
            tx_done_in       = 1'b0;
            pops_since_start = 0;
            prev_grant       = '0;
            return;
        end
        if (grant_out != '0 && prev_grant == '0) session++;
        prev_grant = grant_out;

        if (tx_start_out) begin
            g = idx_of(grant_out);
            checkOutput("grant_onehot", $countones(grant_out), 1);
            checkOutput("pops_per_start", pops_since_start, 1);
            pops_since_start = 0;
            start_cycle = cyc;
            start_grant.push_back(g);
            start_session.push_back(session);
            exp_take(g, tmp_ok, tmp_b);
            checkOutput("sb_avail", tmp_ok, 1);
            if (tmp_ok) checkOutput("tx_data", tx_data_out, tmp_b);
        end

        if (pending_valid) begin
            req_data_in[pending_idx*DATA_BITS +: DATA_BITS] = pending_byte;
            pending_valid = 1'b0;
        end
        if (req_read_out != '0) begin
            r = idx_of(req_read_out);
            checkOutput("read_onehot", $countones(req_read_out), 1);
            checkOutput("pop_not_empty", req_empty_in[r], 0);
            pops_since_start++;
            total_reads++;
            read_cycle = cyc;
            fifo_take(r, tmp_ok, tmp_b);
            if (tmp_ok) begin
                pending_byte  = tmp_b;
                pending_idx   = r;
                pending_valid = 1'b1;
            end
            // Junk until the read latency has elapsed.
            req_data_in[r*DATA_BITS +: DATA_BITS] = 8'hEE;
        end

        tx_done_in = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) tx_done_in = 1'b1;
        end
        if (tx_start_out && uart_delay > 0) uart_cnt = uart_delay;
        update_flags();
    endtask

    task automatic wait_idle(input int max_cycles);
        done_flag = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (!busy_out && fifo0.size() == 0 && fifo1.size() == 0 && uart_cnt == 0 && !pending_valid) begin
                done_flag = 1'b1;
                break;
            end
        end
        if (!done_flag) checkOutput("idle_timeout", done_flag, 1);
    endtask

    task automatic do_reset();
        nrst_in = 1'b0;
        repeat (3) tick();
        nrst_in = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        start_grant.delete();
        start_session.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        nrst_in      = 1'b0;
        req_data_in  = '0;
        tx_done_in   = 1'b0;
        err_clr_in   = 1'b0;
        update_flags();
        repeat (2) tick();
        checkOutput("rst_grant", grant_out, 0);
        checkOutput("rst_busy", busy_out, 0);
        checkOutput("rst_read", req_read_out, 0);
        checkOutput("rst_start", tx_start_out, 0);
        checkOutput("rst_data", tx_data_out, 0);
        checkOutput("rst_err", timeout_err_out, 0);
        nrst_in = 1'b1;
        tick();

        $display("[TB] single source");
        clear_logs();
        base = cyc;
        applyStimulus(0, 8'hA5);
        wait_idle(100);
        checkOutput("t1_read_lat", read_cycle - base, 1);
        checkOutput("t1_start_lat", start_cycle - base, 2 + RD_LATENCY);
        checkOutput("t1_nstarts", start_grant.size(), 1);
        if (start_grant.size() > 0) checkOutput("t1_grant", start_grant[0], 0);
        checkOutput("t1_idle_grant", grant_out, 0);

        // rr_ptr should now point at requester 1.
        clear_logs();
        applyStimulus(0, 8'h01);
        applyStimulus(1, 8'h02);
        wait_idle(200);
        checkOutput("rr1_nstarts", start_grant.size(), 2);
        if (start_grant.size() == 2) begin
            checkOutput("rr1_first", start_grant[0], 1);
            checkOutput("rr1_second", start_grant[1], 0);
        end

        $display("[TB] burst limit");
        clear_logs();
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h10 + 8'(i));
        wait_idle(500);
        checkOutput("burst_nstarts", start_grant.size(), 6);
        if (start_grant.size() == 6) begin
            for (int i = 0; i < 6; i++) checkOutput("burst_grant", start_grant[i], 0);
            checkOutput("burst_same_a", start_session[3] - start_session[0], 0);
            checkOutput("burst_new", start_session[4] - start_session[3], 1);
            checkOutput("burst_same_b", start_session[5] - start_session[4], 0);
        end

        $display("[TB] round robin");
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 8'h20 + 8'(i));
            applyStimulus(1, 8'h30 + 8'(i));
        end
        wait_idle(1000);
        checkOutput("rr_nstarts", start_grant.size(), 16);
        if (start_grant.size() == 16) begin
            for (int j = 0; j < 16; j++) begin
                checkOutput("rr_grant", start_grant[j], (j / 4) % 2);
                checkOutput("rr_session", start_session[j] - start_session[0], j / 4);
            end
        end

        $display("[TB] watchdog");
        uart_delay  = 0;
        start_cycle = -1;
        base        = total_reads;
        applyStimulus(0, 8'h44);
        for (int i = 0; i < 20 && start_cycle < 0; i++) tick();
        if (start_cycle < 0) checkOutput("wd_start_timeout", start_cycle, 0);
        // The flag registers on the edge that ends the TIMEOUT_CYCLES-th WAIT_DONE cycle.
        for (int k = 1; k <= TIMEOUT_CYCLES + 1; k++) begin
            tick();
            if (k == TIMEOUT_CYCLES) begin
                checkOutput("wd_err_early", timeout_err_out, 0);
                checkOutput("wd_busy_early", busy_out, 1);
            end
            if (k == TIMEOUT_CYCLES + 1) begin
                checkOutput("wd_err_set", timeout_err_out, 1);
                checkOutput("wd_grant_rel", grant_out, 0);
                checkOutput("wd_busy_rel", busy_out, 0);
            end
        end
        repeat (5) tick();
        checkOutput("wd_no_repop", total_reads - base, 1);
        checkOutput("wd_err_sticky", timeout_err_out, 1);
        err_clr_in = 1'b1;
        tick();
        err_clr_in = 1'b0;
        checkOutput("wd_err_clr", timeout_err_out, 0);

        $display("[TB] done on expiry cycle");
        uart_delay = TIMEOUT_CYCLES;
        clear_logs();
        applyStimulus(0, 8'h50);
        applyStimulus(0, 8'h51);
        wait_idle(400);
        checkOutput("exp_err", timeout_err_out, 0);
        checkOutput("exp_nstarts", start_grant.size(), 2);
        if (start_grant.size() == 2) checkOutput("exp_same_burst", start_session[1] - start_session[0], 0);

        $display("[TB] reset mid transfer");
        uart_delay = 3;
        read_cycle = -1;
        applyStimulus(1, 8'h66);
        for (int i = 0; i < 20 && read_cycle < 0; i++) tick();
        if (read_cycle < 0) checkOutput("mid_read_timeout", read_cycle, 0);
        tick();
        nrst_in = 1'b0;
        #1;
        checkOutput("mid_read", req_read_out, 0);
        checkOutput("mid_start", tx_start_out, 0);
        checkOutput("mid_grant", grant_out, 0);
        checkOutput("mid_busy", busy_out, 0);
        checkOutput("mid_data", tx_data_out, 0);
        exp_take(1, tmp_ok, tmp_b);
        repeat (2) tick();
        nrst_in = 1'b1;
        tick();
        clear_logs();
        applyStimulus(0, 8'h70);
        applyStimulus(1, 8'h71);
        wait_idle(200);
        checkOutput("post_rst_nstarts", start_grant.size(), 2);
        if (start_grant.size() == 2) begin
            checkOutput("post_rst_first", start_grant[0], 0);
            checkOutput("post_rst_second", start_grant[1], 1);
        end

        checkOutput("sb_left0", exp0.size(), 0);
        checkOutput("sb_left1", exp1.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
